// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Bridges a cache pmem port (one full line per request) to a
//                narrower physical-memory bus. A line is moved as a burst of
//                BEATS beats, and a single-cycle resp_o is returned to the
//                cache once the whole line has been transferred.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   // cache side
   input  logic               read_i,
   input  logic               write_i,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   // memory side
   output logic [ADDR_W-1:0]  address_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);

   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   // Clears the byte-offset bits so the burst always starts on a line boundary.
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'((64'd1 << OFF_W) - 64'd1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   // A line that is not a whole number of beats cannot be bursted.
   generate
      if ((LINE_W % BURST_W) != 0) begin : g_param_check
         $error("cacheline_adaptor: LINE_W must be a multiple of BURST_W");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [LINE_W-1:0]   line_q,  line_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;

   // Register update; reset drops any burst in flight without a response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state, beat bookkeeping and handshake outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      addr_d  = addr_q;
      read_o  = 1'b0;
      write_o = 1'b0;
      resp_o  = 1'b0;

      case (state_q)
         IDLE: begin
            // Write has priority so a dirty victim is flushed before a refill.
            if (write_i) begin
               line_d  = line_i;
               addr_d  = address_i & ADDR_MASK;
               state_d = WR;
            end else if (read_i) begin
               addr_d  = address_i & ADDR_MASK;
               state_d = RD;
            end
         end

         RD: begin
            read_o = 1'b1;
            if (resp_i) begin
               line_d[cnt_q*BURST_W +: BURST_W] = burst_i;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         WR: begin
            write_o = 1'b1;
            if (resp_i) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         DONE: begin
            // Requests still held high here are deliberately not sampled.
            resp_o  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign line_o    = line_q;
   assign address_o = addr_q;
   assign burst_o   = line_q[cnt_q*BURST_W +: BURST_W];

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Self-checking bench for cacheline_adaptor. Drivers push the
//                expected line responses and write beats into queues; a
//                monitor pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst_n;
   logic         read_i;
   logic         write_i;
   logic [31:0]  address_i;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic         resp_o;
   logic [31:0]  address_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   typedef struct {
      bit           is_rd;
      logic [255:0] line;
      logic [31:0]  addr;
   } resp_t;

   resp_t       exp_resp[$];
   logic [63:0] exp_beat[$];
   logic [31:0] exp_addr;
   int          n_checks;
   int          n_fail;
   bit          prev_resp;

   cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read_i    (read_i),
      .write_i   (write_i),
      .address_i (address_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .resp_o    (resp_o),
      .address_o (address_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queues.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (read_o === 1'b1 || write_o === 1'b1)
            chk("address_o", 256'(address_o), 256'(exp_addr));
         if (write_o === 1'b1 && resp_i === 1'b1) begin
            if (exp_beat.size() == 0)
               chk("unexpected_wr_beat", 256'(1), 256'(0));
            else
               chk("burst_o", 256'(burst_o), 256'(exp_beat.pop_front()));
         end
         if (resp_o === 1'b1) begin
            chk("resp_single_pulse", 256'(prev_resp), 256'(0));
            if (exp_resp.size() == 0) begin
               chk("unexpected_resp", 256'(1), 256'(0));
            end else begin
               resp_t r;
               r = exp_resp.pop_front();
               if (r.is_rd) chk("line_o", line_o, r.line);
               chk("resp_addr", 256'(address_o), 256'(r.addr));
               chk("resp_rw_low", 256'({read_o, write_o}), 256'(0));
            end
         end
         prev_resp = (resp_o === 1'b1);
      end else begin
         prev_resp = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read burst; abort_at>0 asserts reset after that many accepted beats.
   task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] pat, input int n, input int abort_at);
      int k;
      resp_t r;
      k = 0;
      exp_addr = addr & 32'hFFFF_FFE0;
      if (abort_at == 0) begin
         r.is_rd = 1'b1;
         r.line  = line;
         r.addr  = exp_addr;
         exp_resp.push_back(r);
      end
      read_i    = 1'b1;
      address_i = addr;
      tick();
      read_i    = 1'b0;
      address_i = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         if (abort_at != 0 && k == abort_at) break;
         chk("read_o_during_burst", 256'(read_o), 256'(1));
         resp_i  = pat[i];
         burst_i = pat[i] ? line[k*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
         tick();
         if (pat[i]) k++;
      end
      resp_i  = 1'b0;
      burst_i = '0;
      if (abort_at != 0) begin
         rst_n = 1'b0;
         tick();
         chk("abort_read_o", 256'(read_o), 256'(0));
         chk("abort_resp_o", 256'(resp_o), 256'(0));
         chk("abort_line_o", line_o, 256'(0));
         chk("abort_address_o", 256'(address_o), 256'(0));
         rst_n = 1'b1;
         tick();
         chk("abort_idle_resp", 256'(resp_o), 256'(0));
      end else begin
         chk("read_o_after_last", 256'(read_o), 256'(0));
         chk("rd_resp_latency", 256'(resp_o), 256'(1));
         tick();
         chk("rd_resp_drop", 256'(resp_o), 256'(0));
      end
   endtask

   // Write burst; also_read raises read_i alongside write_i.
   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int n, input bit also_read);
      resp_t r;
      exp_addr = addr & 32'hFFFF_FFE0;
      r.is_rd = 1'b0;
      r.line  = line;
      r.addr  = exp_addr;
      exp_resp.push_back(r);
      for (int b = 0; b < 4; b++) exp_beat.push_back(line[b*64 +: 64]);
      write_i   = 1'b1;
      read_i    = also_read;
      address_i = addr;
      line_i    = line;
      tick();
      write_i   = 1'b0;
      read_i    = 1'b0;
      address_i = '0;
      line_i    = '0;
      for (int i = 0; i < n; i++) begin
         chk("write_o_during_burst", 256'(write_o), 256'(1));
         chk("read_o_during_write", 256'(read_o), 256'(0));
         resp_i = pat[i];
         tick();
      end
      resp_i = 1'b0;
      chk("write_o_after_last", 256'(write_o), 256'(0));
      chk("wr_resp_latency", 256'(resp_o), 256'(1));
      tick();
      chk("wr_resp_drop", 256'(resp_o), 256'(0));
   endtask

   localparam logic [255:0] RD_LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] WR_LINE   = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [255:0] RD_LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0};
   localparam logic [255:0] RD_LINE_C = {64'hC0DE_0004_C0DE_0004, 64'hC0DE_0003_C0DE_0003,
                                         64'hC0DE_0002_C0DE_0002, 64'hC0DE_0001_C0DE_0001};
   localparam logic [255:0] WR_LINE_2 = {64'h9999_0000_9999_0000, 64'h8888_0000_8888_0000,
                                         64'h7777_0000_7777_0000, 64'h6666_0000_6666_0000};

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      prev_resp = 1'b0;
      exp_addr  = '0;
      rst_n     = 1'b0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      address_i = 32'h1234_5678;
      line_i    = {8{32'hA5A5_5A5A}};
      burst_i   = 64'hFFFF_FFFF_FFFF_FFFF;
      resp_i    = 1'b0;

      // 1: reset
      tick();
      tick();
      chk("rst_line_o", line_o, 256'(0));
      chk("rst_burst_o", 256'(burst_o), 256'(0));
      chk("rst_address_o", 256'(address_o), 256'(0));
      chk("rst_resp_o", 256'(resp_o), 256'(0));
      chk("rst_read_o", 256'(read_o), 256'(0));
      chk("rst_write_o", 256'(write_o), 256'(0));
      rst_n = 1'b1;
      line_i = '0;
      tick();

      // 2: back-to-back read, address 0x1234 aligns to 0x1220
      do_read(32'h0000_1234, RD_LINE_A, 16'b1111, 4, 0);
      chk("rd_address_o_aligned", 256'(address_o), 256'(32'h0000_1220));
      tick();

      // 3: back-to-back write at 0x40
      do_write(32'h0000_0040, WR_LINE, 16'b1111, 4, 1'b0);
      tick();

      // 4: read with gaps 1,0,0,1,1,0,1 (bit i = cycle i)
      do_read(32'h0000_ABCD, RD_LINE_B, 16'b1011001, 7, 0);
      tick();

      // 5: reset after two beats, then a fresh read
      do_read(32'h0000_2000, RD_LINE_A, 16'b1111, 4, 2);
      do_read(32'h0000_3000, RD_LINE_C, 16'b1111, 4, 0);

      // 6a: stray resp_i in IDLE is ignored
      resp_i  = 1'b1;
      burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      tick();
      chk("stray_read_o", 256'(read_o), 256'(0));
      chk("stray_write_o", 256'(write_o), 256'(0));
      chk("stray_resp_o", 256'(resp_o), 256'(0));
      chk("stray_line_o", line_o, RD_LINE_C);
      resp_i  = 1'b0;
      burst_i = '0;
      tick();

      // 6b: read and write together -> write wins, with a gap in acks
      do_write(32'h0000_5F7F, WR_LINE_2, 16'b11011, 5, 1'b1);
      tick();
      tick();

      chk("resp_queue_drained", 256'(exp_resp.size()), 256'(0));
      chk("beat_queue_drained", 256'(exp_beat.size()), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
